// File: rtl/core_exec_unit.sv
// RV32I execute stage: operand bypass/select (prep) feeding ALU, branch compare and target (alu).
// Define CORE_EXEC_ALU_2_STAGE_EN to insert a resettable, flushable register between prep and alu.
module core_exec_unit (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_flush,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [1:0]  i_bp_rs1,
    input  logic [1:0]  i_bp_rs2,
    input  logic [31:0] i_rs1_val,
    input  logic [31:0] i_rs2_val,
    input  logic [31:0] i_memory_rd_val,
    input  logic [31:0] i_write_rd_val,
    input  logic [31:0] i_write_back_rd_val,
    input  logic        i_alu_op1_sel,
    input  logic        i_alu_op2_sel,
    input  logic [29:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [4:0]  i_alu_ctrl,
    input  logic        i_jump,
    input  logic        i_branch,
    input  logic        i_pc_sel,
    output logic [31:0] o_alu_result,
    output logic        o_pc_src,
    output logic [29:0] o_pc_target,
    output logic [31:0] o_rs2_val
);

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] bp1;
        logic [31:0] bp2;
        logic [31:0] imm;
        logic [29:0] pc;
        logic [4:0]  alu_ctrl;
        logic        jump;
        logic        branch;
        logic        pc_sel;
    } stage_t;

    logic [31:0] bp1, bp2;
    stage_t      stage_d, stage;
    logic        unused;

    // ---------------- prep: bypass and operand select ----------------
    always_comb begin
        bp1 = '0;
        if (i_rs1 != 5'd0) begin
            case (i_bp_rs1)
                2'b00:   bp1 = i_rs1_val;
                2'b01:   bp1 = i_memory_rd_val;
                2'b10:   bp1 = i_write_rd_val;
                default: bp1 = i_write_back_rd_val;
            endcase
        end
    end

    always_comb begin
        bp2 = '0;
        if (i_rs2 != 5'd0) begin
            case (i_bp_rs2)
                2'b00:   bp2 = i_rs2_val;
                2'b01:   bp2 = i_memory_rd_val;
                2'b10:   bp2 = i_write_rd_val;
                default: bp2 = i_write_back_rd_val;
            endcase
        end
    end

    always_comb begin
        stage_d          = '0;
        stage_d.op1      = i_alu_op1_sel ? {i_pc, 2'b00} : bp1;
        stage_d.op2      = i_alu_op2_sel ? i_imm : bp2;
        stage_d.bp1      = bp1;
        stage_d.bp2      = bp2;
        stage_d.imm      = i_imm;
        stage_d.pc       = i_pc;
        stage_d.alu_ctrl = i_alu_ctrl;
        stage_d.jump     = i_jump;
        stage_d.branch   = i_branch;
        stage_d.pc_sel   = i_pc_sel;
    end

    // ---------------- optional stage register ----------------
    logic [31:0] target_sum;

`ifdef CORE_EXEC_ALU_2_STAGE_EN
    stage_t stage_q;

    // A cleared register decodes as ADD 0+0 with no redirect, so all outputs read zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stage_q <= '0;
        end else if (i_flush) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign stage  = stage_q;
    assign unused = ^target_sum[1:0];
`else
    assign stage  = stage_d;
    assign unused = ^{i_clk, i_reset, i_flush, target_sum[1:0]};
`endif

    // ---------------- alu: arithmetic, compare, target ----------------
    logic [31:0] diff;
    logic        cond;

    assign diff = stage.op1 - stage.op2;

    always_comb begin
        o_alu_result = '0;
        cond         = 1'b0;
        case (stage.alu_ctrl)
            5'b00000: o_alu_result = stage.op1 + stage.op2;
            5'b00001: o_alu_result = diff;
            5'b00010: o_alu_result = stage.op1 << stage.op2[4:0];
            5'b00011: o_alu_result = {31'd0, $signed(stage.op1) < $signed(stage.op2)};
            5'b00100: o_alu_result = {31'd0, stage.op1 < stage.op2};
            5'b00101: o_alu_result = stage.op1 ^ stage.op2;
            5'b00110: o_alu_result = stage.op1 >> stage.op2[4:0];
            5'b00111: o_alu_result = $unsigned($signed(stage.op1) >>> stage.op2[4:0]);
            5'b01000: o_alu_result = stage.op1 | stage.op2;
            5'b01001: o_alu_result = stage.op1 & stage.op2;
            5'b01010: o_alu_result = stage.op2;
            5'b10000: begin o_alu_result = diff; cond = (stage.op1 == stage.op2); end
            5'b10001: begin o_alu_result = diff; cond = (stage.op1 != stage.op2); end
            5'b10100: begin o_alu_result = diff; cond = ($signed(stage.op1) < $signed(stage.op2)); end
            5'b10101: begin o_alu_result = diff; cond = ($signed(stage.op1) >= $signed(stage.op2)); end
            5'b10110: begin o_alu_result = diff; cond = (stage.op1 < stage.op2); end
            5'b10111: begin o_alu_result = diff; cond = (stage.op1 >= stage.op2); end
            default: ;
        endcase
    end

    // Low two sum bits are dropped: JALR clears bit 0 and there is no misalignment trap.
    assign target_sum  = (stage.pc_sel ? stage.bp1 : {stage.pc, 2'b00}) + stage.imm;
    assign o_pc_target = target_sum[31:2];
    assign o_pc_src    = stage.jump | (stage.branch & cond);
    assign o_rs2_val   = stage.bp2;

endmodule

// File: tb/tb_core_exec_unit.sv
// Self-checking bench for core_exec_unit: behavioural model compared every cycle plus literal pins.
// Covers both builds; CORE_EXEC_ALU_2_STAGE_EN selects the one-cycle-latency expectations.
module tb_core_exec_unit;

    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  bp1s;
        logic [1:0]  bp2s;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] mem;
        logic [31:0] wr;
        logic [31:0] wb;
        logic        op1_sel;
        logic        op2_sel;
        logic [29:0] pc;
        logic [31:0] imm;
        logic [4:0]  ctrl;
        logic        jump;
        logic        branch;
        logic        pc_sel;
        logic        flush;
    } in_t;

    typedef struct packed {
        logic [31:0] res;
        logic        src;
        logic [29:0] tgt;
        logic [31:0] rs2;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    in_t         vin;
    logic [31:0] d_res;
    logic        d_src;
    logic [29:0] d_tgt;
    logic [31:0] d_rs2;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        started = 1'b0;
    out_t        exp_q = '0;

    always #5 clk = ~clk;

    core_exec_unit dut (
        .i_clk               (clk),
        .i_reset             (rst),
        .i_flush             (vin.flush),
        .i_rs1               (vin.rs1),
        .i_rs2               (vin.rs2),
        .i_bp_rs1            (vin.bp1s),
        .i_bp_rs2            (vin.bp2s),
        .i_rs1_val           (vin.rs1_val),
        .i_rs2_val           (vin.rs2_val),
        .i_memory_rd_val     (vin.mem),
        .i_write_rd_val      (vin.wr),
        .i_write_back_rd_val (vin.wb),
        .i_alu_op1_sel       (vin.op1_sel),
        .i_alu_op2_sel       (vin.op2_sel),
        .i_pc                (vin.pc),
        .i_imm               (vin.imm),
        .i_alu_ctrl          (vin.ctrl),
        .i_jump              (vin.jump),
        .i_branch            (vin.branch),
        .i_pc_sel            (vin.pc_sel),
        .o_alu_result        (d_res),
        .o_pc_src            (d_src),
        .o_pc_target         (d_tgt),
        .o_rs2_val           (d_rs2)
    );

    function automatic logic [31:0] fwd(logic [4:0] idx, logic [1:0] sel, logic [31:0] own,
                                        in_t v);
        logic [31:0] src [4];
        src[0] = own;
        src[1] = v.mem;
        src[2] = v.wr;
        src[3] = v.wb;
        return (idx == 5'd0) ? 32'd0 : src[sel];
    endfunction

    function automatic out_t model(in_t v);
        out_t        o;
        logic [31:0] x, y, a, b, sum;
        int signed   sa, sb;
        logic        take;
        x     = fwd(v.rs1, v.bp1s, v.rs1_val, v);
        y     = fwd(v.rs2, v.bp2s, v.rs2_val, v);
        a     = v.op1_sel ? v.pc * 32'd4 : x;
        b     = v.op2_sel ? v.imm : y;
        sa    = a;
        sb    = b;
        take  = 1'b0;
        o     = '0;
        case (v.ctrl)
            5'd0:  o.res = a + b;
            5'd1:  o.res = a - b;
            5'd2:  o.res = a << (b % 32);
            5'd3:  o.res = (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  o.res = (a < b) ? 32'd1 : 32'd0;
            5'd5:  o.res = a ^ b;
            5'd6:  o.res = a >> (b % 32);
            5'd7:  o.res = sa >>> (b % 32);
            5'd8:  o.res = a | b;
            5'd9:  o.res = a & b;
            5'd10: o.res = b;
            5'd16, 5'd17, 5'd20, 5'd21, 5'd22, 5'd23: begin
                o.res = a - b;
                case (v.ctrl)
                    5'd16:   take = (a == b);
                    5'd17:   take = (a != b);
                    5'd20:   take = (sa < sb);
                    5'd21:   take = !(sa < sb);
                    5'd22:   take = (a < b);
                    default: take = !(a < b);
                endcase
            end
            default: o.res = 32'd0;
        endcase
        o.src = v.jump || (v.branch && take);
        sum   = (v.pc_sel ? x : v.pc * 32'd4) + v.imm;
        o.tgt = sum[31:2];
        o.rs2 = y;
        return o;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

`ifdef CORE_EXEC_ALU_2_STAGE_EN
    always @(posedge clk or posedge rst) begin
        if (rst)            exp_q <= '0;
        else if (vin.flush) exp_q <= '0;
        else                exp_q <= model(vin);
    end
`endif

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (started) begin
            out_t e;
`ifdef CORE_EXEC_ALU_2_STAGE_EN
            e = exp_q;
`else
            e = model(vin);
`endif
            chk("cyc_result", d_res, e.res);
            chk("cyc_pc_src", {31'd0, d_src}, {31'd0, e.src});
            chk("cyc_target", {2'd0, d_tgt}, {2'd0, e.tgt});
            chk("cyc_rs2_val", d_rs2, e.rs2);
        end
    end

    function automatic in_t dflt();
        in_t v;
        v     = '0;
        v.rs1 = 5'd1;
        v.rs2 = 5'd2;
        return v;
    endfunction

    task automatic begin_vec();
        @(posedge clk);
        #1;
        vin = dflt();
    endtask

    // Pin the model (and, combinationally, the DUT) to hand-computed values; mask: 1 res 2 src 4 tgt 8 rs2.
    task automatic pin(string name, int mask, logic [31:0] er, logic es, logic [29:0] et,
                       logic [31:0] e2);
        out_t m;
        m = model(vin);
        #1;
        if (mask[0]) chk({name, "_res"}, m.res, er);
        if (mask[1]) chk({name, "_src"}, {31'd0, m.src}, {31'd0, es});
        if (mask[2]) chk({name, "_tgt"}, {2'd0, m.tgt}, {2'd0, et});
        if (mask[3]) chk({name, "_rs2"}, m.rs2, e2);
`ifndef CORE_EXEC_ALU_2_STAGE_EN
        if (mask[0]) chk({name, "_dut_res"}, d_res, er);
        if (mask[1]) chk({name, "_dut_src"}, {31'd0, d_src}, {31'd0, es});
        if (mask[2]) chk({name, "_dut_tgt"}, {2'd0, d_tgt}, {2'd0, et});
        if (mask[3]) chk({name, "_dut_rs2"}, d_rs2, e2);
`endif
    endtask

    initial begin
        vin = dflt();
        #1 rst = 1'b1;
        #1 started = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        begin_vec();  // bypass via write_rd_val
        vin.rs1 = 5'd5; vin.bp1s = 2'b10; vin.wr = 32'h1234; vin.rs2_val = 32'd7;
        pin("bypass", 9, 32'h123B, 0, 0, 32'd7);
        begin_vec();
        vin.rs1 = 5'd0; vin.bp1s = 2'b10; vin.wr = 32'h1234; vin.rs2_val = 32'd7;
        pin("bypass_x0", 1, 32'd7, 0, 0, 0);
        begin_vec();  // memory / write-back forwarding, rs2 = x0 store data
        vin.bp1s = 2'b01; vin.mem = 32'h100; vin.bp2s = 2'b11; vin.wb = 32'h23;
        pin("bypass_mem_wb", 9, 32'h123, 0, 0, 32'h23);
        begin_vec();
        vin.rs2 = 5'd0; vin.bp2s = 2'b01; vin.mem = 32'h55; vin.rs1_val = 32'd9;
        pin("store_x0", 9, 32'd9, 0, 0, 32'd0);

        begin_vec();
        vin.rs1_val = 32'h8000_0000; vin.op2_sel = 1; vin.imm = 32'd35; vin.ctrl = 5'b00111;
        pin("sra", 1, 32'hF000_0000, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'h8000_0000; vin.op2_sel = 1; vin.imm = 32'd4; vin.ctrl = 5'b00110;
        pin("srl", 1, 32'h0800_0000, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'd1; vin.op2_sel = 1; vin.imm = 32'h24; vin.ctrl = 5'b00010;
        pin("sll", 1, 32'h10, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'd1; vin.rs2_val = 32'hFFFF_FFFF; vin.ctrl = 5'b00100;
        pin("sltu", 1, 32'd1, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'd1; vin.rs2_val = 32'hFFFF_FFFF; vin.ctrl = 5'b00011;
        pin("slt", 1, 32'd0, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'd10; vin.rs2_val = 32'd3; vin.ctrl = 5'b00001;
        pin("sub", 1, 32'd7, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'hF0F0; vin.rs2_val = 32'h0FF0; vin.ctrl = 5'b00101;
        pin("xor", 1, 32'hFF00, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'hF000; vin.rs2_val = 32'h000F; vin.ctrl = 5'b01000;
        pin("or", 1, 32'hF00F, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'hFF00; vin.rs2_val = 32'h0FF0; vin.ctrl = 5'b01001;
        pin("and", 1, 32'h0F00, 0, 0, 0);

        begin_vec();  // BLT taken
        vin.rs1_val = 32'hFFFF_FFFF; vin.rs2_val = 32'd1; vin.branch = 1; vin.pc = 30'h40;
        vin.imm = 32'hFFFF_FFF8; vin.ctrl = 5'b10100;
        pin("blt", 7, 32'hFFFF_FFFE, 1, 30'h3E, 0);
        begin_vec();
        vin.rs1_val = 32'hFFFF_FFFF; vin.rs2_val = 32'd1; vin.branch = 1; vin.pc = 30'h40;
        vin.imm = 32'hFFFF_FFF8; vin.ctrl = 5'b10111;
        pin("bgeu", 6, 0, 1, 30'h3E, 0);
        begin_vec();
        vin.rs1_val = 32'hFFFF_FFFF; vin.rs2_val = 32'd1; vin.branch = 1; vin.ctrl = 5'b10101;
        pin("bge", 2, 0, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'hFFFF_FFFF; vin.rs2_val = 32'd1; vin.branch = 1; vin.ctrl = 5'b10110;
        pin("bltu", 2, 0, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'd5; vin.rs2_val = 32'd5; vin.branch = 1; vin.ctrl = 5'b10000;
        pin("beq", 3, 0, 1, 0, 0);
        begin_vec();
        vin.rs1_val = 32'd5; vin.rs2_val = 32'd5; vin.branch = 1; vin.ctrl = 5'b10001;
        pin("bne", 2, 0, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'd5; vin.rs2_val = 32'd5; vin.ctrl = 5'b10000;
        pin("beq_nobranch", 2, 0, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'd5; vin.rs2_val = 32'd5; vin.branch = 1; vin.ctrl = 5'b01011;
        pin("unlisted_01011", 3, 0, 0, 0, 0);
        begin_vec();
        vin.rs1_val = 32'd5; vin.rs2_val = 32'd5; vin.branch = 1; vin.ctrl = 5'b10010;
        pin("unlisted_10010", 3, 0, 0, 0, 0);

        begin_vec();  // JALR
        vin.rs1 = 5'd3; vin.rs1_val = 32'h2003; vin.jump = 1; vin.pc_sel = 1; vin.imm = 32'd4;
        vin.pc = 30'h123;
        pin("jalr", 6, 0, 1, 30'h801, 0);
        begin_vec();  // AUIPC
        vin.op1_sel = 1; vin.pc = 30'h100; vin.op2_sel = 1; vin.imm = 32'h1000;
        pin("auipc", 5, 32'h1400, 0, 30'h500, 0);
        begin_vec();  // LUI
        vin.op2_sel = 1; vin.imm = 32'hABCD_E000; vin.ctrl = 5'b01010;
        pin("lui", 1, 32'hABCD_E000, 0, 0, 0);

        for (int i = 0; i < 32; i++) begin
            begin_vec();
            vin.rs1     = 5'($urandom_range(0, 3));
            vin.rs2     = 5'($urandom_range(0, 3));
            vin.bp1s    = 2'($urandom);
            vin.bp2s    = 2'($urandom);
            vin.rs1_val = $urandom;
            vin.rs2_val = $urandom;
            vin.mem     = $urandom;
            vin.wr      = $urandom;
            vin.wb      = $urandom;
            vin.op1_sel = 1'($urandom);
            vin.op2_sel = 1'($urandom);
            vin.pc      = 30'($urandom);
            vin.imm     = $urandom;
            vin.ctrl    = 5'($urandom);
            vin.jump    = ($urandom_range(0, 7) == 0);
            vin.branch  = 1'($urandom);
            vin.pc_sel  = 1'($urandom);
        end

`ifdef CORE_EXEC_ALU_2_STAGE_EN
        begin_vec();
        vin.rs1_val = 32'h10;
        @(posedge clk);
        #1;
        vin.rs1_val = 32'd3; vin.rs2_val = 32'd4;
        #1 chk("lat_hold", d_res, 32'h10);
        @(posedge clk);
        #1 chk("lat_follow", d_res, 32'd7);

        begin_vec();  // mid-cycle reset
        vin.rs1_val = 32'd9; vin.jump = 1; vin.pc = 30'h77; vin.rs2_val = 32'd6;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_res", d_res, 32'd0);
        chk("rst_src", {31'd0, d_src}, 32'd0);
        chk("rst_tgt", {2'd0, d_tgt}, 32'd0);
        chk("rst_rs2", d_rs2, 32'd0);
        #1 rst = 1'b0;

        begin_vec();  // flush a taken branch
        vin.rs1_val = 32'd5; vin.rs2_val = 32'd5; vin.branch = 1; vin.ctrl = 5'b10000;
        vin.flush = 1;
        pin("flush_prep", 2, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("flush_src", {31'd0, d_src}, 32'd0);
        chk("flush_res", d_res, 32'd0);
        vin.flush = 0;
        @(posedge clk);
        #1 chk("after_flush_src", {31'd0, d_src}, 32'd1);
`else
        begin_vec();  // reset/flush must not disturb the combinational path
        vin.rs1_val = 32'd3; vin.rs2_val = 32'd4; vin.flush = 1;
        #1 rst = 1'b1;
        #1 chk("comb_rst_res", d_res, 32'd7);
        #1 rst = 1'b0;
`endif

        repeat (2) @(posedge clk);
        #1 started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
